sb_lane_xform: RTL and testbench

//  Synthesizable switchboard-stream packet transformer between an SB RX port and an SB TX port.

---
 rtl/sb_xform_pkg.sv | 32 +++
 rtl/sb_xform_fifo.sv | 64 ++++++
 rtl/sb_lane_xform.sv | 121 ++++++++++++
 tb/tb_sb_lane_xform.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_xform_pkg.sv
// Shared types and lane arithmetic for the switchboard lane transformer.
package sb_xform_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_XOR  = 2'd3
    } op_e;

    typedef enum logic {
        StIdle,
        StInPkt
    } state_e;

    // Lane math runs at this width; callers keep the low LANEW bits, which is modulo 2^LANEW.
    localparam int unsigned LaneMaxW = 32;

    function automatic logic [LaneMaxW-1:0] lane_op(input op_e op,
                                                    input logic [LaneMaxW-1:0] a,
                                                    input logic [LaneMaxW-1:0] k);
        logic [LaneMaxW-1:0] r;
        case (op)
            OP_ADD:  r = a + k;
            OP_SUB:  r = a - k;
            OP_XOR:  r = a ^ k;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_xform_fifo.sv
// Synchronous FIFO with occupancy count; head entry reads as zero while empty.
module sb_xform_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [Width-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [Width-1:0]           rd_data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Full blocks a push even when a pop happens in the same cycle.
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_en_i && !empty_o;

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/sb_lane_xform.sv
// Switchboard packet transformer: per-lane op with a per-packet latched constant, elastic buffer.
// Optional packet/beat counters are built when SB_XFORM_STATS_EN is defined.
module sb_lane_xform
    import sb_xform_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned DESTW = 32,
    parameter int unsigned LANEW = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_op,
    input  logic [LANEW-1:0] cfg_k,
    input  logic [DW-1:0]    in_data,
    input  logic [DESTW-1:0] in_dest,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [DESTW-1:0] out_dest,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef SB_XFORM_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [31:0]      stat_pkts,
    output logic [31:0]      stat_beats
`endif
);

    localparam int unsigned Lanes = DW / LANEW;
    localparam int unsigned EntW  = DW + DESTW + 1;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    state_e           state_q;
    op_e              op_q;
    logic [LANEW-1:0] k_q;
    op_e              eff_op;
    logic [LANEW-1:0] eff_k;
    logic [DW-1:0]    xf_data;
    logic [CntW-1:0]  fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push;

    assign push   = in_valid && in_ready;
    // First beat of a packet uses the live config; the rest reuse what it latched.
    assign eff_op = (state_q == StIdle) ? op_e'(cfg_op) : op_q;
    assign eff_k  = (state_q == StIdle) ? cfg_k : k_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= OP_PASS;
            k_q     <= '0;
        end else if (push) begin
            case (state_q)
                StIdle: begin
                    op_q    <= op_e'(cfg_op);
                    k_q     <= cfg_k;
                    state_q <= in_last ? StIdle : StInPkt;
                end
                default: begin
                    if (in_last) state_q <= StIdle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        logic [LaneMaxW-1:0] res;
        assign res = lane_op(eff_op, LaneMaxW'(in_data[i*LANEW +: LANEW]), LaneMaxW'(eff_k));
        assign xf_data[i*LANEW +: LANEW] = res[LANEW-1:0];
        if (LANEW < LaneMaxW) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^res[LaneMaxW-1:LANEW];
        end
    end

    sb_xform_fifo #(
        .Width (EntW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (push),
        .wr_data_i ({in_last, in_dest, xf_data}),
        .rd_en_i   (out_ready),
        .rd_data_o ({out_last, out_dest, out_data}),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign busy      = (state_q == StInPkt) || (fifo_count != '0);

`ifdef SB_XFORM_STATS_EN
    logic [31:0] stat_pkts_q, stat_beats_q;
    logic        pop;

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_pkts_q  <= '0;
            stat_beats_q <= '0;
        end else if (pop) begin
            stat_beats_q <= stat_beats_q + 32'd1;
            if (out_last) stat_pkts_q <= stat_pkts_q + 32'd1;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule

// File: tb/tb_sb_lane_xform.sv
// Directed and randomised-backpressure bench for sb_lane_xform (default build parameters).
module tb_sb_lane_xform;

    localparam int unsigned DW    = 256;
    localparam int unsigned DESTW = 32;
    localparam int unsigned LANEW = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       cfg_op;
    logic [LANEW-1:0] cfg_k;
    logic [DW-1:0]    in_data;
    logic [DESTW-1:0] in_dest;
    logic             in_last, in_valid, in_ready;
    logic [DW-1:0]    out_data;
    logic [DESTW-1:0] out_dest;
    logic             out_last, out_valid, out_ready, busy;
`ifdef SB_XFORM_STATS_EN
    logic             stat_clr;
    logic [31:0]      stat_pkts, stat_beats;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sb_lane_xform #(
        .DW    (DW),
        .DESTW (DESTW),
        .LANEW (LANEW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_op    (cfg_op),
        .cfg_k     (cfg_k),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef SB_XFORM_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_pkts (stat_pkts),
        .stat_beats(stat_beats)
`endif
    );

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 8; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    // Drives one beat from a negedge and returns just after the edge that accepted it.
    task automatic send(input logic [DW-1:0] d, input logic [DESTW-1:0] dst, input logic lst);
        int t;
        @(negedge clk);
        in_data  = d;
        in_dest  = dst;
        in_last  = lst;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_dest !== '0) begin n_fail++; $display("FAIL reset_out_dest: got %h want 0", out_dest); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    endtask

    task automatic test_reset_mid_packet();
        cfg_op = 2'd1; cfg_k = 8'h02; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(fill(8'h20 + 8'(i)), 32'(i), 1'b0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
        // Next packet must take the live config (XOR 0x0F): 0x33 ^ 0x0F = 0x3C.
        cfg_op = 2'd3; cfg_k = 8'h0F;
        send(fill(8'h33), 32'h5, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== fill(8'h3C)) begin n_fail++; $display("FAIL midrst_next_data: got %h want %h", out_data, fill(8'h3C)); end
        n_cmp++; if (out_dest !== 32'h5) begin n_fail++; $display("FAIL midrst_next_dest: got %h want 5", out_dest); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_add_single();
        logic [DW-1:0] d, e;
        d = fill(8'h10); d[7:0] = 8'h00; d[15:8] = 8'h7F; d[23:16] = 8'hFF;
        e = fill(8'h11); e[7:0] = 8'h01; e[15:8] = 8'h80; e[23:16] = 8'h00;
        cfg_op = 2'd1; cfg_k = 8'h01; out_ready = 1'b0;
        send(d, 32'h1234, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== e) begin n_fail++; $display("FAIL add_data: got %h want %h", out_data, e); end
        n_cmp++; if (out_dest !== 32'h1234) begin n_fail++; $display("FAIL add_dest: got %h want 1234", out_dest); end
        n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL add_last: got %b want 1", out_last); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy: got %b want 0", busy); end
    endtask

    task automatic test_op_latch();
        logic [7:0] exp_b [4];
        logic       exp_l [4];
        // ADD 3 for the whole first packet, then XOR 3 for the next one.
        exp_b = '{8'h04, 8'h05, 8'h06, 8'h02};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1};
        cfg_op = 2'd1; cfg_k = 8'h03; out_ready = 1'b0;
        send(fill(8'h01), 32'd1, 1'b0);
        cfg_op = 2'd3;
        send(fill(8'h02), 32'd2, 1'b0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL latch_busy: got %b want 1", busy); end
        send(fill(8'h03), 32'd3, 1'b1);
        send(fill(8'h01), 32'd4, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (out_data !== fill(exp_b[i])) begin n_fail++; $display("FAIL latch_data%0d: got %h want %h", i, out_data, fill(exp_b[i])); end
            n_cmp++; if (out_last !== exp_l[i]) begin n_fail++; $display("FAIL latch_last%0d: got %b want %b", i, out_last, exp_l[i]); end
            n_cmp++; if (out_dest !== 32'(i + 1)) begin n_fail++; $display("FAIL latch_dest%0d: got %0d want %0d", i, out_dest, i + 1); end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latch_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        cfg_op = 2'd0; cfg_k = 8'h00; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(fill(8'h40 + 8'(i)), 32'(100 + i), 1'b1);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        // Offer a fifth beat while the first pop happens: it must wait a cycle, not slip in.
        out_ready = 1'b1;
        in_data = fill(8'h55); in_dest = 32'h99; in_last = 1'b1; in_valid = 1'b1;
        n_cmp++; if (out_data !== fill(8'h40)) begin n_fail++; $display("FAIL full_beat0: got %h want %h", out_data, fill(8'h40)); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== fill(8'h41)) begin n_fail++; $display("FAIL full_beat1: got %h want %h", out_data, fill(8'h41)); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int j = 2; j < 4; j++) begin
            @(negedge clk);
            n_cmp++; if (out_data !== fill(8'h40 + 8'(j))) begin n_fail++; $display("FAIL full_beat%0d: got %h want %h", j, out_data, fill(8'h40 + 8'(j))); end
            n_cmp++; if (out_dest !== 32'(100 + j)) begin n_fail++; $display("FAIL full_dest%0d: got %0d want %0d", j, out_dest, 100 + j); end
        end
        @(negedge clk);
        n_cmp++; if (out_data !== fill(8'h55)) begin n_fail++; $display("FAIL full_beat4: got %h want %h", out_data, fill(8'h55)); end
        n_cmp++; if (out_dest !== 32'h99) begin n_fail++; $display("FAIL full_dest4: got %h want 99", out_dest); end
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back_random();
        logic [DW-1:0]    q_data [$];
        logic [DESTW-1:0] q_dest [$];
        logic             q_last [$];
        logic [DW-1:0]    d;
        logic             pending, pop, push;
        int               sent, rcvd, cyc;
        cfg_op = 2'd3; cfg_k = 8'h5A;
        pending = 1'b0; sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            n_cmp++; if (out_valid !== (q_data.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid cyc%0d: got %b want %b", cyc, out_valid, q_data.size() != 0); end
            n_cmp++; if (in_ready !== (q_data.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready cyc%0d: got %b occupancy %0d", cyc, in_ready, q_data.size()); end
            if (!pending) in_valid = 1'b0;
            if (!pending && sent < 1000 && $urandom_range(3) != 0) begin
                for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
                in_data = d; in_dest = $urandom; in_last = 1'($urandom_range(1));
                in_valid = 1'b1; pending = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            pop  = out_valid && out_ready;
            push = in_valid && in_ready;
            if (pop && q_data.size() != 0) begin
                n_cmp++;
                if (out_data !== q_data[0] || out_dest !== q_dest[0] || out_last !== q_last[0]) begin
                    n_fail++;
                    $display("FAIL rnd_beat%0d: got %h/%h/%b want %h/%h/%b", rcvd, out_data, out_dest, out_last, q_data[0], q_dest[0], q_last[0]);
                end
                void'(q_data.pop_front()); void'(q_dest.pop_front()); void'(q_last.pop_front());
                rcvd++;
            end
            if (push) begin
                q_data.push_back(in_data ^ fill(8'h5A));
                q_dest.push_back(in_dest);
                q_last.push_back(in_last);
                sent++;
                pending = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (rcvd != 1000) begin n_fail++; $display("FAIL rnd_count: got %0d beats want 1000", rcvd); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_leftover: got %b want 0", out_valid); end
    endtask

`ifdef SB_XFORM_STATS_EN
    task automatic test_stats();
        out_ready = 1'b1; cfg_op = 2'd0;
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        for (int p = 0; p < 5; p++) begin
            send(fill(8'(p)), 32'(p), 1'b0);
            send(fill(8'(p)), 32'(p), 1'b1);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (stat_pkts !== 32'd5) begin n_fail++; $display("FAIL stat_pkts: got %0d want 5", stat_pkts); end
        n_cmp++; if (stat_beats !== 32'd10) begin n_fail++; $display("FAIL stat_beats: got %0d want 10", stat_beats); end
        stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        n_cmp++; if (stat_pkts !== 32'd0) begin n_fail++; $display("FAIL stat_pkts_clr: got %0d want 0", stat_pkts); end
        n_cmp++; if (stat_beats !== 32'd0) begin n_fail++; $display("FAIL stat_beats_clr: got %0d want 0", stat_beats); end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; cfg_op = 2'd0; cfg_k = '0;
        in_data = '0; in_dest = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SB_XFORM_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_reset_mid_packet();
        test_add_single();
        test_op_latch();
        test_full();
        test_back_to_back_random();
`ifdef SB_XFORM_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
